// File: rtl/sram_dp_pkg.sv
// Shared types and helpers for the sram_dp_buf dual-port buffer.
package sram_dp_pkg;

    typedef enum logic [0:0] {S_INIT, S_RUN} state_e;

    localparam int unsigned RD_LAT_MIN = 1;
    localparam int unsigned RD_LAT_MAX = 2;

    // Widest word the merge helper handles; callers cast down to DATA_W.
    localparam int unsigned MERGE_W  = 512;
    localparam int unsigned MSTRB_W  = MERGE_W / 8;

    function automatic logic [MERGE_W-1:0] strb_merge(input logic [MERGE_W-1:0] old_word,
                                                      input logic [MERGE_W-1:0] new_word,
                                                      input logic [MSTRB_W-1:0] strb);
        logic [MERGE_W-1:0] res;
        for (int i = 0; i < int'(MSTRB_W); i++) begin
            res[i*8 +: 8] = strb[i] ? new_word[i*8 +: 8] : old_word[i*8 +: 8];
        end
        return res;
    endfunction

endpackage

// File: rtl/sram_dp_rd_pipe.sv
// Read-return pipeline: RD_LAT stages of valid/data; data only moves with valid,
// so the output word holds between reads.
module sram_dp_rd_pipe #(
    parameter int unsigned DATA_W = 16,
    parameter int unsigned RD_LAT = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    output logic [DATA_W-1:0] out_data
);

    logic [RD_LAT-1:0] valid_q;
    logic [DATA_W-1:0] data_q [RD_LAT];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= '0;
            for (int i = 0; i < int'(RD_LAT); i++) begin
                data_q[i] <= '0;
            end
        end else begin
            valid_q[0] <= in_valid;
            if (in_valid) begin
                data_q[0] <= in_data;
            end
            for (int i = 1; i < int'(RD_LAT); i++) begin
                valid_q[i] <= valid_q[i-1];
                if (valid_q[i-1]) begin
                    data_q[i] <= data_q[i-1];
                end
            end
        end
    end

    assign out_valid = valid_q[RD_LAT-1];
    assign out_data  = data_q[RD_LAT-1];

endmodule

// File: rtl/sram_dp_buf.sv
// True dual-port buffer with zero-fill sweep, byte-enable writes and A-wins collisions.
// Define SRAM_DP_BYPASS_EN for write-first cross-port reads (default read-before-write).
module sram_dp_buf
    import sram_dp_pkg::*;
#(
    parameter int unsigned DATA_W = 16,
    parameter int unsigned DEPTH  = 32768,
    parameter int unsigned ADDR_W = $clog2(DEPTH),
    parameter int unsigned RD_LAT = 1,
    parameter int unsigned CNT_W  = 16
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                clear_i,
    output logic                ready_o,

    input  logic                a_req_i,
    input  logic                a_we_i,
    input  logic [ADDR_W-1:0]   a_addr_i,
    input  logic [DATA_W-1:0]   a_wdata_i,
    input  logic [DATA_W/8-1:0] a_wstrb_i,
    output logic                a_rvalid_o,
    output logic [DATA_W-1:0]   a_rdata_o,

    input  logic                b_req_i,
    input  logic                b_we_i,
    input  logic [ADDR_W-1:0]   b_addr_i,
    input  logic [DATA_W-1:0]   b_wdata_i,
    input  logic [DATA_W/8-1:0] b_wstrb_i,
    output logic                b_rvalid_o,
    output logic [DATA_W-1:0]   b_rdata_o,

    output logic                coll_o,
    output logic [CNT_W-1:0]    coll_cnt_o
);

    localparam int unsigned STRB_W = DATA_W / 8;
    localparam int unsigned LAT    = (RD_LAT < RD_LAT_MIN) ? RD_LAT_MIN :
                                     (RD_LAT > RD_LAT_MAX) ? RD_LAT_MAX : RD_LAT;
    localparam logic [ADDR_W-1:0] LAST_PTR = ADDR_W'(DEPTH - 1);

    function automatic logic [DATA_W-1:0] merge(input logic [DATA_W-1:0] old_word,
                                                input logic [DATA_W-1:0] new_word,
                                                input logic [STRB_W-1:0] strb);
        return DATA_W'(strb_merge(MERGE_W'(old_word), MERGE_W'(new_word), MSTRB_W'(strb)));
    endfunction

    logic [DATA_W-1:0] mem [DEPTH];

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] ptr_q, ptr_d;
    logic              coll_q;
    logic [CNT_W-1:0]  cnt_q, cnt_d;

    logic a_in_rng, b_in_rng;
    logic a_wr, b_wr_raw, b_wr, a_rd, b_rd, coll;
    logic [DATA_W-1:0] a_rd_word, b_rd_word;

    // Sweep FSM
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_INIT;
            ptr_q   <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
        end
    end

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        ready_o = 1'b0;
        unique case (state_q)
            S_INIT: begin
                ptr_d = ptr_q + ADDR_W'(1);
                if (ptr_q == LAST_PTR) begin
                    state_d = S_RUN;
                    ptr_d   = '0;
                end
            end
            S_RUN:   ready_o = 1'b1;
            default: ;
        endcase
        if (clear_i) begin
            state_d = S_INIT;
            ptr_d   = '0;
        end
    end

    // Access decode; nothing is accepted while the sweep is running.
    assign a_in_rng = 32'(a_addr_i) < DEPTH;
    assign b_in_rng = 32'(b_addr_i) < DEPTH;
    assign a_wr     = ready_o & a_req_i & a_we_i & a_in_rng & (|a_wstrb_i);
    assign b_wr_raw = ready_o & b_req_i & b_we_i & b_in_rng & (|b_wstrb_i);
    assign coll     = a_wr & b_wr_raw & (a_addr_i == b_addr_i);
    assign b_wr     = b_wr_raw & ~coll;
    assign a_rd     = ready_o & a_req_i & ~a_we_i;
    assign b_rd     = ready_o & b_req_i & ~b_we_i;

    always_comb begin
        a_rd_word = '0;
        b_rd_word = '0;
        if (a_in_rng) begin
            a_rd_word = mem[a_addr_i];
        end
        if (b_in_rng) begin
            b_rd_word = mem[b_addr_i];
        end
`ifdef SRAM_DP_BYPASS_EN
        if (b_wr && (b_addr_i == a_addr_i)) begin
            a_rd_word = merge(a_rd_word, b_wdata_i, b_wstrb_i);
        end
        if (a_wr && (a_addr_i == b_addr_i)) begin
            b_rd_word = merge(b_rd_word, a_wdata_i, a_wstrb_i);
        end
`endif
    end

    always_ff @(posedge clk) begin
        if (state_q == S_INIT) begin
            mem[ptr_q] <= '0;
        end
        if (b_wr) begin
            mem[b_addr_i] <= merge(mem[b_addr_i], b_wdata_i, b_wstrb_i);
        end
        if (a_wr) begin
            mem[a_addr_i] <= merge(mem[a_addr_i], a_wdata_i, a_wstrb_i);
        end
    end

    // Collision reporting
    always_comb begin
        cnt_d = cnt_q;
        if (clear_i) begin
            cnt_d = '0;
        end else if (coll && (cnt_q != '1)) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            coll_q <= 1'b0;
            cnt_q  <= '0;
        end else begin
            coll_q <= coll;
            cnt_q  <= cnt_d;
        end
    end

    assign coll_o     = coll_q;
    assign coll_cnt_o = cnt_q;

    sram_dp_rd_pipe #(
        .DATA_W (DATA_W),
        .RD_LAT (LAT)
    ) u_rd_pipe_a (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (a_rd),
        .in_data   (a_rd_word),
        .out_valid (a_rvalid_o),
        .out_data  (a_rdata_o)
    );

    sram_dp_rd_pipe #(
        .DATA_W (DATA_W),
        .RD_LAT (LAT)
    ) u_rd_pipe_b (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (b_rd),
        .in_data   (b_rd_word),
        .out_valid (b_rvalid_o),
        .out_data  (b_rdata_o)
    );

endmodule

// File: doc/sram_dp_buf.md
Name: sram_dp_buf

Overview:
- Parametrised, single-clock, true dual-port on-chip buffer; next generation of the team's fixed 16b x 32768w dual-port SRAM wrapper.
- Adds configurable width/depth and byte-enable writes.
- Adds programmable read latency, per-port req/rvalid handshake and a self-clearing init sweep.
- Detects and resolves same-address collisions. Sits between the CNN accelerator datapath (port A) and the DMA/loader (port B).

Parameters:
- DATA_W, 16, word width in bits; multiple of 8.
- DEPTH, 32768, number of words.
- ADDR_W, $clog2(DEPTH), address width.
- RD_LAT, 1, read latency in cycles; legal values 1 or 2.
- CNT_W, 16, collision counter width.

Ports:
- clk  in  1  clock; all logic on rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- clear_i  in  1  one-cycle pulse; restarts the zero-fill sweep.
- ready_o  out  1  high when the array is usable (RUN state).
- a_req_i  in  1  port A access request.
- a_we_i  in  1  port A write (1) / read (0).
- a_addr_i  in  ADDR_W  port A word address.
- a_wdata_i  in  DATA_W  port A write data.
- a_wstrb_i  in  DATA_W/8  port A byte enables.
- a_rvalid_o  out  1  port A read data valid.
- a_rdata_o  out  DATA_W  port A read data.
- b_req_i, b_we_i, b_addr_i, b_wdata_i, b_wstrb_i, b_rvalid_o, b_rdata_o: same as port A, for port B.
- coll_o  out  1  registered pulse: write-write collision resolved.
- coll_cnt_o  out  CNT_W  saturating collision count.

Behaviour:
- Reset values: ready_o=0, a/b_rvalid_o=0, a/b_rdata_o=0, coll_o=0, coll_cnt_o=0, FSM=S_INIT, sweep pointer=0. Array contents are not reset directly; the sweep clears them.
- FSM S_INIT: each cycle writes 0 to word[ptr] and increments ptr.
  - At ptr==DEPTH-1 the FSM moves to S_RUN on the next edge.
  - S_INIT therefore lasts exactly DEPTH cycles after reset release.
- FSM S_RUN: ready_o=1.
  - clear_i=1 forces S_INIT with ptr=0, and clears coll_cnt_o.
  - clear_i during S_INIT restarts the sweep at ptr=0.
- Requests while ready_o=0 are dropped: no write, no rvalid.
- Read: request accepted at edge N; rvalid_o and rdata_o are valid at edge N+RD_LAT for exactly one cycle. Back-to-back reads sustain one per cycle per port.
- rdata_o holds its last value when rvalid_o=0.
- Write: bytes with wstrb=1 update at the accepting edge. wstrb=0 on a write request is a no-op; it does not count as a collision.
- Same-port read-after-write on consecutive cycles returns the new data.
- A write and B read (or vice versa) to the same address in the same cycle: the read returns the old word (read-before-write).
- A write and B write to the same address in the same cycle, both with non-zero wstrb:
  - Port A wins; port B's write is dropped entirely.
  - coll_o pulses high on the next cycle.
  - coll_cnt_o increments and saturates at 2^CNT_W-1.
- Both ports reading the same address: no conflict, and both ports get the data.
- Asynchronous reset mid-operation: the read pipelines flush (no stale rvalid), and the FSM returns to S_INIT.
- Addresses at or above DEPTH (DEPTH not a power of 2): writes are ignored; reads return 0 with rvalid asserted.

Optional Feature:
- Macro: SRAM_DP_BYPASS_EN.
- Defined: a same-cycle cross-port read of an address being written returns the write-merged word (write-first), i.e. the new bytes where wstrb=1 and old bytes elsewhere.
- Undefined: read-before-write as specified above.
- The write-write collision rule is unchanged in both cases.

Decomposition:
- Package sram_dp_pkg:
  - state enum state_e {S_INIT, S_RUN};
  - localparams for legal RD_LAT range;
  - function strb_merge(old, new, strb) returning the byte-merged word.
- Sub-module sram_dp_rd_pipe, instantiated once per port:
  - RD_LAT-deep valid/data shift register with async reset;
  - parameters DATA_W, RD_LAT.

Test Plan:
- Reset release, DEPTH=16 -> ready_o rises exactly 16 cycles after rst_n deasserts. All 16 reads then return 0x0000.
- A writes 0xBEEF at addr 3, wstrb=2'b11; next cycle B reads addr 3 with RD_LAT=2 -> b_rvalid_o two cycles later with 0xBEEF.
- A writes 0x1234 at addr 5, then A writes 0xAB00 with wstrb=2'b10; then A reads addr 5 -> 0xAB34.
- Same cycle: A writes 0x1111 and B writes 0x2222 at addr 7 -> word=0x1111, coll_o pulses 1 cycle, coll_cnt_o=1. Repeat with CNT_W=2 four times -> coll_cnt_o saturates at 3.
- Same cycle: A writes 0x5555 at addr 9 (old value 0x0000) and B reads addr 9 -> b_rdata_o=0x0000 without SRAM_DP_BYPASS_EN, 0x5555 with it.
- clear_i mid-traffic, plus a read issued one cycle earlier -> ready_o=0 next cycle and requests during init are dropped. After DEPTH cycles, all words read 0 and coll_cnt_o=0.
